// File: rtl/channel_start_scheduler_pkg.sv
// ============================================================================
// Module : channel_start_scheduler_pkg
// Brief  : Shared FSM state encoding and sizing defaults for the start scheduler.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package channel_start_scheduler_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SCAN = 3'd1,
    S_WAIT = 3'd2,
    S_RUN  = 3'd3,
    S_DONE = 3'd4
  } sched_state_e;

  localparam int CH_NUM_DEFAULT    = 16;
  localparam int DELAY_BIT_DEFAULT = 16;
  localparam int CFG_SEL_W         = 4;

  // Index width that stays legal for a single-channel build.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/channel_start_scheduler_delay_cnt.sv
// ============================================================================
// Module : sched_delay_cnt
// Brief  : Loadable down-counter that saturates at zero; flags the zero count.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sched_delay_cnt #(
  parameter int DELAY_BIT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_load,
  input  logic [DELAY_BIT-1:0] i_load_val,
  input  logic                 i_dec,
  output logic                 o_zero
);

  logic [DELAY_BIT-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - DELAY_BIT'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/channel_start_scheduler.sv
// ============================================================================
// Module : channel_start_scheduler
// Brief  : Fires per-channel start ticks in ascending order after programmable
//          delays, tracks one-shot completion and supports abort.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module channel_start_scheduler
  import channel_start_scheduler_pkg::*;
#(
  parameter int CH_NUM    = CH_NUM_DEFAULT,
  parameter int DELAY_BIT = DELAY_BIT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_cfg_we,
  input  logic [CFG_SEL_W-1:0] i_cfg_sel,
  input  logic                 i_cfg_enable,
  input  logic                 i_cfg_wait,
  input  logic [DELAY_BIT-1:0] i_cfg_delay,
  input  logic                 i_go,
  input  logic                 i_abort,
  input  logic [CH_NUM-1:0]    i_ch_done_tick,
  output logic [CH_NUM-1:0]    o_start_tick,
  output logic [CH_NUM-1:0]    o_stop,
  output logic                 o_busy,
  output logic                 o_done_tick
);

  localparam int IDX_W = idx_width(CH_NUM);

  sched_state_e         r_state, w_state_nxt;
  logic [IDX_W-1:0]     r_idx, w_idx_nxt;
  logic [CH_NUM-1:0]    r_enable, r_wait;
  logic [DELAY_BIT-1:0] r_delay [CH_NUM];
  logic [CH_NUM-1:0]    r_pending, w_pending_nxt;
  logic [CH_NUM-1:0]    r_fired, w_fired_nxt;
  logic [CH_NUM-1:0]    w_start_nxt, w_stop_nxt;
  logic                 w_done_nxt;
  logic                 w_cnt_load, w_cnt_dec, w_cnt_zero;
  logic                 w_cfg_wr, w_sel_ok, w_last;
  logic [IDX_W-1:0]     w_sel_idx;
  logic [DELAY_BIT-1:0] w_load_val;

  assign w_sel_ok   = ({{(32-CFG_SEL_W){1'b0}}, i_cfg_sel} < CH_NUM);
  assign w_sel_idx  = i_cfg_sel[IDX_W-1:0];
  assign w_last     = (r_idx == IDX_W'(CH_NUM - 1));
  assign w_load_val = r_delay[r_idx];

  sched_delay_cnt #(
    .DELAY_BIT (DELAY_BIT)
  ) u_delay_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_cnt_load),
    .i_load_val (w_load_val),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_pending_nxt = r_pending;
    w_fired_nxt   = r_fired;
    w_start_nxt   = '0;
    w_stop_nxt    = '0;
    w_done_nxt    = 1'b0;
    w_cnt_load    = 1'b0;
    w_cnt_dec     = 1'b0;
    w_cfg_wr      = 1'b0;

    if (r_state != S_IDLE) begin
      w_pending_nxt = r_pending & ~i_ch_done_tick;
    end

    case (r_state)
      S_IDLE: begin
        if (i_go) begin
          w_idx_nxt   = '0;
          w_fired_nxt = '0;
          w_state_nxt = (|r_enable) ? S_SCAN : S_DONE;
        end else if (i_cfg_we && w_sel_ok) begin
          w_cfg_wr = 1'b1;
        end
      end
      S_SCAN: begin
        if (r_enable[r_idx]) begin
          w_cnt_load  = 1'b1;
          w_state_nxt = S_WAIT;
        end else if (w_last) begin
          w_state_nxt = S_RUN;
        end else begin
          w_idx_nxt = r_idx + IDX_W'(1);
        end
      end
      S_WAIT: begin
        if (!w_cnt_zero) begin
          w_cnt_dec = 1'b1;
        end else begin
          // Setting the pending bit after the clear makes a same-edge set win.
          w_start_nxt[r_idx]   = 1'b1;
          w_pending_nxt[r_idx] = r_wait[r_idx];
          w_fired_nxt[r_idx]   = 1'b1;
          if (w_last) begin
            w_state_nxt = S_RUN;
          end else begin
            w_idx_nxt   = r_idx + IDX_W'(1);
            w_state_nxt = S_SCAN;
          end
        end
      end
      S_RUN: begin
        if (r_pending == '0) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_done_nxt  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Abort overrides every transition and output decided above.
    if ((r_state != S_IDLE) && i_abort) begin
      w_stop_nxt    = r_pending | r_fired;
      w_pending_nxt = '0;
      w_start_nxt   = '0;
      w_done_nxt    = 1'b0;
      w_cnt_load    = 1'b0;
      w_cnt_dec     = 1'b0;
      w_state_nxt   = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_enable     <= '0;
      r_wait       <= '0;
      r_pending    <= '0;
      r_fired      <= '0;
      o_start_tick <= '0;
      o_stop       <= '0;
      o_busy       <= 1'b0;
      o_done_tick  <= 1'b0;
      for (int i = 0; i < CH_NUM; i++) begin
        r_delay[i] <= '0;
      end
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_pending    <= w_pending_nxt;
      r_fired      <= w_fired_nxt;
      o_start_tick <= w_start_nxt;
      o_stop       <= w_stop_nxt;
      o_busy       <= (r_state != S_IDLE);
      o_done_tick  <= w_done_nxt;
      if (w_cfg_wr) begin
        r_enable[w_sel_idx] <= i_cfg_enable;
        r_wait[w_sel_idx]   <= i_cfg_wait;
        r_delay[w_sel_idx]  <= i_cfg_delay;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_channel_start_scheduler.sv
// ============================================================================
// Module : tb_channel_start_scheduler
// Brief  : Scoreboard bench; expected per-cycle outputs are derived from the
//          channel timing rules and compared each cycle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_channel_start_scheduler;

  localparam int CH = 16;

  logic          clk;
  logic          rst_n;
  logic          i_cfg_we;
  logic [3:0]    i_cfg_sel;
  logic          i_cfg_enable;
  logic          i_cfg_wait;
  logic [15:0]   i_cfg_delay;
  logic          i_go;
  logic          i_abort;
  logic [CH-1:0] i_ch_done_tick;
  logic [CH-1:0] o_start_tick;
  logic [CH-1:0] o_stop;
  logic          o_busy;
  logic          o_done_tick;

  typedef struct packed {
    logic [15:0] start;
    logic [15:0] stop;
    logic        done;
    logic        busy;
  } obs_t;

  obs_t        sb[$];
  obs_t        got, exp_v;
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [CH-1:0] m_en, m_wt;
  logic [15:0]   m_dly [CH];

  channel_start_scheduler #(.CH_NUM(16), .DELAY_BIT(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_cfg_we       (i_cfg_we),
    .i_cfg_sel      (i_cfg_sel),
    .i_cfg_enable   (i_cfg_enable),
    .i_cfg_wait     (i_cfg_wait),
    .i_cfg_delay    (i_cfg_delay),
    .i_go           (i_go),
    .i_abort        (i_abort),
    .i_ch_done_tick (i_ch_done_tick),
    .o_start_tick   (o_start_tick),
    .o_stop         (o_stop),
    .o_busy         (o_busy),
    .o_done_tick    (o_done_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Window w is the interval after edge Ew; go is sampled at E0.
  // Disabled channel: 1 cycle of scan. Enabled: D+2 cycles, start visible at end.
  task automatic plan(input int rel_win, input int abort_win, input int tail);
    int   s, r, last;
    int   fire_w [CH];
    logic [15:0] fired;
    obs_t e;
    s = 0;
    fired = '0;
    for (int ch = 0; ch < CH; ch++) fire_w[ch] = -1;
    if (m_en == '0) begin
      r = -1;
    end else begin
      for (int ch = 0; ch < CH; ch++) begin
        if (m_en[ch]) begin
          fire_w[ch] = s + int'(m_dly[ch]) + 2;
          s = fire_w[ch];
        end else begin
          s = s + 1;
        end
      end
      r = (rel_win + 1 > s) ? rel_win + 1 : s;
    end
    last = (abort_win >= 0) ? abort_win + 1 : r + 2;
    for (int ch = 0; ch < CH; ch++)
      if (fire_w[ch] >= 0 && fire_w[ch] <= abort_win) fired[ch] = 1'b1;
    for (int w = 0; w <= last + tail; w++) begin
      e = '0;
      for (int ch = 0; ch < CH; ch++)
        if (fire_w[ch] == w && (abort_win < 0 || w <= abort_win)) e.start[ch] = 1'b1;
      e.busy = (w >= 1 && w <= last);
      e.done = (abort_win < 0 && w == r + 2);
      if (abort_win >= 0 && w == abort_win + 1) e.stop = fired;
      sb.push_back(e);
    end
  endtask

  task automatic cfg_write(input int ch, input logic en, input logic wt, input logic [15:0] d);
    i_cfg_we     = 1'b1;
    i_cfg_sel    = 4'(ch);
    i_cfg_enable = en;
    i_cfg_wait   = wt;
    i_cfg_delay  = d;
    @(negedge clk);
    i_cfg_we = 1'b0;
    m_en[ch]  = en;
    m_wt[ch]  = wt;
    m_dly[ch] = d;
  endtask

  task automatic clear_cfg();
    for (int ch = 0; ch < CH; ch++) cfg_write(ch, 1'b0, 1'b0, 16'd0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    got = {o_start_tick, o_stop, o_done_tick, o_busy};
    n_checks++;
    if (got !== '0) begin
      n_fail++;
      $display("FAIL reset_hold: got %h, expected 0", got);
    end
    rst_n = 1'b1;
    @(negedge clk);
    got = {o_start_tick, o_stop, o_done_tick, o_busy};
    n_checks++;
    if (got !== '0) begin
      n_fail++;
      $display("FAIL reset_release: got %h, expected 0", got);
    end
    for (int ch = 0; ch < CH; ch++) begin
      m_en[ch] = 1'b0; m_wt[ch] = 1'b0; m_dly[ch] = 16'd0;
    end
  endtask

  task automatic test_basic();
    int n;
    clear_cfg();
    cfg_write(0, 1'b1, 1'b1, 16'd3);
    cfg_write(2, 1'b1, 1'b1, 16'd0);
    plan(24, -1, 2);
    n = sb.size();
    i_go = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      got = {o_start_tick, o_stop, o_done_tick, o_busy};
      exp_v = sb.pop_front();
      n_checks++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL basic w%0d: got start=%h stop=%h done=%b busy=%b, expected start=%h stop=%h done=%b busy=%b",
                 k, got.start, got.stop, got.done, got.busy, exp_v.start, exp_v.stop, exp_v.done, exp_v.busy);
      end
      i_go = 1'b0;
      i_ch_done_tick = (k == 10) ? 16'h0001 : (k == 12) ? 16'h0020 : (k == 24) ? 16'h0004 : 16'h0000;
    end
  endtask

  task automatic test_no_enable();
    int n;
    clear_cfg();
    plan(-1, -1, 2);
    n = sb.size();
    i_go = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      got = {o_start_tick, o_stop, o_done_tick, o_busy};
      exp_v = sb.pop_front();
      n_checks++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL no_enable w%0d: got start=%h stop=%h done=%b busy=%b, expected start=%h stop=%h done=%b busy=%b",
                 k, got.start, got.stop, got.done, got.busy, exp_v.start, exp_v.stop, exp_v.done, exp_v.busy);
      end
      i_go = 1'b0;
    end
  endtask

  task automatic test_repeat();
    int n;
    clear_cfg();
    cfg_write(1, 1'b1, 1'b0, 16'd1);
    cfg_write(3, 1'b1, 1'b1, 16'd2);
    plan(22, -1, 2);
    n = sb.size();
    i_go = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      got = {o_start_tick, o_stop, o_done_tick, o_busy};
      exp_v = sb.pop_front();
      n_checks++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL repeat w%0d: got start=%h stop=%h done=%b busy=%b, expected start=%h stop=%h done=%b busy=%b",
                 k, got.start, got.stop, got.done, got.busy, exp_v.start, exp_v.stop, exp_v.done, exp_v.busy);
      end
      i_go = 1'b0;
      i_ch_done_tick = (k == 22) ? 16'h0008 : 16'h0000;
    end
  endtask

  task automatic test_abort();
    int n;
    clear_cfg();
    cfg_write(0, 1'b1, 1'b1, 16'd0);
    cfg_write(1, 1'b1, 1'b1, 16'd0);
    plan(-1, 19, 3);
    n = sb.size();
    i_go = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      got = {o_start_tick, o_stop, o_done_tick, o_busy};
      exp_v = sb.pop_front();
      n_checks++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL abort w%0d: got start=%h stop=%h done=%b busy=%b, expected start=%h stop=%h done=%b busy=%b",
                 k, got.start, got.stop, got.done, got.busy, exp_v.start, exp_v.stop, exp_v.done, exp_v.busy);
      end
      i_go = 1'b0;
      // Second abort lands in idle and must have no effect.
      i_abort = (k == 19 || k == 21);
    end
    i_abort = 1'b0;
  endtask

  task automatic test_cfg_lock();
    int n;
    clear_cfg();
    cfg_write(0, 1'b1, 1'b0, 16'd0);
    for (int run = 0; run < 2; run++) begin
      plan(-1, -1, 2);
      n = sb.size();
      i_go = 1'b1;
      if (run == 1) begin
        i_cfg_we = 1'b1; i_cfg_sel = 4'd6; i_cfg_enable = 1'b1; i_cfg_wait = 1'b0; i_cfg_delay = 16'd0;
      end
      for (int k = 0; k < n; k++) begin
        @(negedge clk);
        got = {o_start_tick, o_stop, o_done_tick, o_busy};
        exp_v = sb.pop_front();
        n_checks++;
        if (got !== exp_v) begin
          n_fail++;
          $display("FAIL cfg_lock r%0d w%0d: got start=%h stop=%h done=%b busy=%b, expected start=%h stop=%h done=%b busy=%b",
                   run, k, got.start, got.stop, got.done, got.busy, exp_v.start, exp_v.stop, exp_v.done, exp_v.busy);
        end
        i_go = 1'b0;
        i_cfg_we = (run == 0 && k == 3);
        i_cfg_sel = 4'd4; i_cfg_enable = 1'b1; i_cfg_wait = 1'b1; i_cfg_delay = 16'd0;
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    clear_cfg();
    cfg_write(0, 1'b1, 1'b1, 16'd20);
    plan(-1, -1, 0);
    i_go = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      got = {o_start_tick, o_stop, o_done_tick, o_busy};
      exp_v = sb.pop_front();
      n_checks++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL reset_mid w%0d: got start=%h stop=%h done=%b busy=%b, expected start=%h stop=%h done=%b busy=%b",
                 k, got.start, got.stop, got.done, got.busy, exp_v.start, exp_v.stop, exp_v.done, exp_v.busy);
      end
      i_go = 1'b0;
    end
    sb.delete();
    #1 rst_n = 1'b0;
    #1;
    got = {o_start_tick, o_stop, o_done_tick, o_busy};
    n_checks++;
    if (got !== '0) begin
      n_fail++;
      $display("FAIL reset_async: got %h, expected 0", got);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int ch = 0; ch < CH; ch++) begin
      m_en[ch] = 1'b0; m_wt[ch] = 1'b0; m_dly[ch] = 16'd0;
    end
    @(negedge clk);
    plan(-1, -1, 2);
    n = sb.size();
    i_go = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      got = {o_start_tick, o_stop, o_done_tick, o_busy};
      exp_v = sb.pop_front();
      n_checks++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL reset_rerun w%0d: got start=%h stop=%h done=%b busy=%b, expected start=%h stop=%h done=%b busy=%b",
                 k, got.start, got.stop, got.done, got.busy, exp_v.start, exp_v.stop, exp_v.done, exp_v.busy);
      end
      i_go = 1'b0;
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    i_cfg_we       = 1'b0;
    i_cfg_sel      = 4'd0;
    i_cfg_enable   = 1'b0;
    i_cfg_wait     = 1'b0;
    i_cfg_delay    = 16'd0;
    i_go           = 1'b0;
    i_abort        = 1'b0;
    i_ch_done_tick = '0;
    test_reset();
    test_basic();
    test_no_enable();
    test_repeat();
    test_abort();
    test_cfg_lock();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
